// File: rtl/io_ir_receiver.sv
// io_ir_receiver: bus-mapped IR frame decoder. Measures carrier burst widths
// on the demodulated receiver output, decodes one START + 8-bit frame (MSB
// first), holds the byte in a readable DATA register and raises an interrupt
// on every decoded frame.

module io_ir_receiver #(
  parameter logic [7:0]  BASE_ADDR     = 8'h98,
  parameter int unsigned TICK_DIV      = 2500,
  parameter int unsigned START_TICKS   = 96,
  parameter int unsigned ONE_TICKS     = 48,
  parameter int unsigned ZERO_TICKS    = 24,
  parameter int unsigned TOL_TICKS     = 6,
  parameter int unsigned GAP_MAX_TICKS = 40
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic       IR_IN,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

  localparam logic [7:0] START_LO = 8'(START_TICKS - TOL_TICKS);
  localparam logic [7:0] START_HI = 8'(START_TICKS + TOL_TICKS);
  localparam logic [7:0] ONE_LO   = 8'(ONE_TICKS - TOL_TICKS);
  localparam logic [7:0] ONE_HI   = 8'(ONE_TICKS + TOL_TICKS);
  localparam logic [7:0] ZERO_LO  = 8'(ZERO_TICKS - TOL_TICKS);
  localparam logic [7:0] ZERO_HI  = 8'(ZERO_TICKS + TOL_TICKS);
  localparam logic [7:0] GAP_MAX  = 8'(GAP_MAX_TICKS);
  localparam logic [7:0] DATA_ADDR = BASE_ADDR + 8'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GAP,
    S_BIT,
    S_COMMIT,
    S_ERR,
    S_WAIT_IDLE
  } state_t;

  state_t r_state, w_next;

  logic [1:0]    r_sync;
  logic          r_burst_d;
  logic [TW-1:0] r_div;
  logic [7:0]    r_dur;
  logic [7:0]    r_shift;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ovr;
  logic          r_ferr;
  logic          r_raise;
  logic          r_oe;
  logic [7:0]    r_rd_val;

  logic w_burst, w_rise, w_fall, w_tick;
  logic w_shift, w_bit_val, w_clr_bits, w_commit, w_err;
  logic w_stat_rd, w_data_rd, w_stat_wr;

  assign w_burst   = ~r_sync[1];
  assign w_rise    = w_burst & ~r_burst_d;
  assign w_fall    = ~w_burst & r_burst_d;
  assign w_tick    = (r_div == DIV_LAST);

  assign w_stat_rd = ~BUS_WE & (BUS_ADDR == BASE_ADDR);
  assign w_data_rd = ~BUS_WE & (BUS_ADDR == DATA_ADDR);
  assign w_stat_wr =  BUS_WE & (BUS_ADDR == BASE_ADDR);

  assign BUS_DATA            = r_oe ? r_rd_val : 'z;
  assign BUS_INTERRUPT_RAISE = r_raise;

  // Two-flop synchroniser (preset to idle = no carrier) and edge history
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync    <= '1;
      r_burst_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], IR_IN};
      r_burst_d <= w_burst;
    end
  end

  // Free-running tick prescaler
  always_ff @(posedge CLK) begin
    if (RESET || w_tick) r_div <= '0;
    else                 r_div <= r_div + TW'(1);
  end

  // Saturating tick counter; on an edge it restarts with that cycle's tick
  // so a burst of exactly N*TICK_DIV cycles always measures N ticks
  always_ff @(posedge CLK) begin
    if (RESET)                           r_dur <= '0;
    else if (w_rise || w_fall)           r_dur <= {7'd0, w_tick};
    else if (w_tick && (r_dur != '1))    r_dur <= r_dur + 8'd1;
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state and datapath strobes
  always_comb begin
    w_next     = r_state;
    w_shift    = 1'b0;
    w_bit_val  = 1'b0;
    w_clr_bits = 1'b0;
    w_commit   = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_next = S_START;
      end
      S_START: begin
        if (w_fall) begin
          if (r_dur >= START_LO && r_dur <= START_HI) begin
            w_next     = S_GAP;
            w_clr_bits = 1'b1;
          end else begin
            w_next = S_ERR;
          end
        end else if (w_burst && r_dur > START_HI) begin
          w_next = S_ERR;
        end
      end
      S_GAP: begin
        if (r_dur > GAP_MAX) w_next = S_ERR;
        else if (w_rise)     w_next = S_BIT;
      end
      S_BIT: begin
        if (w_fall) begin
          if (r_dur >= ONE_LO && r_dur <= ONE_HI) begin
            w_shift   = 1'b1;
            w_bit_val = 1'b1;
          end else if (r_dur >= ZERO_LO && r_dur <= ZERO_HI) begin
            w_shift   = 1'b1;
          end
          if (!w_shift)                   w_next = S_ERR;
          else if (r_bit_cnt == 4'd7)     w_next = S_COMMIT;
          else                            w_next = S_GAP;
        end else if (w_burst && r_dur > ONE_HI) begin
          w_next = S_ERR;
        end
      end
      S_COMMIT: begin
        w_commit = 1'b1;
        w_next   = S_IDLE;
      end
      S_ERR: begin
        w_err  = 1'b1;
        w_next = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        // r_dur still holds the burst length on the falling-edge cycle, so
        // the quiet time only counts once the edge history is also low
        if (!w_burst && !r_burst_d && r_dur >= GAP_MAX) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shift register and bit counter; errors discard partial bits
  always_ff @(posedge CLK) begin
    if (RESET || w_clr_bits || w_err) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift   <= {r_shift[6:0], w_bit_val};
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  // Data and status flags; commit outranks a same-cycle DATA read
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_commit) r_data <= r_shift;
      if (w_commit)       r_valid <= 1'b1;
      else if (w_data_rd) r_valid <= 1'b0;
      if (w_commit && r_valid) r_ovr <= 1'b1;
      else if (w_stat_wr)      r_ovr <= 1'b0;
      if (w_err)          r_ferr <= 1'b1;
      else if (w_stat_wr) r_ferr <= 1'b0;
    end
  end

  // Interrupt request: set on commit, cleared by acknowledge, commit wins
  always_ff @(posedge CLK) begin
    if (RESET)                  r_raise <= 1'b0;
    else if (w_commit)          r_raise <= 1'b1;
    else if (BUS_INTERRUPT_ACK) r_raise <= 1'b0;
  end

  // Registered read port: drive value captured when the address is decoded
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_oe     <= 1'b0;
      r_rd_val <= '0;
    end else begin
      r_oe     <= w_stat_rd | w_data_rd;
      r_rd_val <= w_data_rd ? r_data : {5'd0, r_ferr, r_ovr, r_valid};
    end
  end

endmodule

// File: tb/tb_io_ir_receiver.sv
// Bench for io_ir_receiver: directed scenarios plus randomized frames, all
// checked against a frame-level model of the IR protocol and register map.

module tb_io_ir_receiver;

  localparam int TD         = 2;
  localparam logic [7:0] BASE  = 8'h98;
  localparam logic [7:0] DADDR = 8'h99;
  localparam int START_T    = 96;
  localparam int ONE_T      = 48;
  localparam int ZERO_T     = 24;
  localparam int TOL        = 6;
  localparam int GAP_MAX    = 40;
  localparam int IDLE_AFTER = 50;

  logic       clk = 1'b0;
  logic       rst, ir, we, ack, drv_en;
  logic [7:0] addr, drv_val;
  wire  [7:0] bus;
  wire        raise;

  assign bus = drv_en ? drv_val : 'z;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_data;
  bit         m_valid, m_ovr, m_ferr, m_raise;
  int         g_gap[8];
  int         g_bit[8];

  io_ir_receiver #(
    .BASE_ADDR(BASE),
    .TICK_DIV (TD)
  ) dut (
    .CLK                (clk),
    .RESET              (rst),
    .BUS_DATA           (bus),
    .BUS_ADDR           (addr),
    .BUS_WE             (we),
    .IR_IN              (ir),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK  (ack)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_status();
    return {5'b0, m_ferr, m_ovr, m_valid};
  endfunction

  function automatic bit in_win(input int len, input int nom);
    return (len >= nom - TOL) && (len <= nom + TOL);
  endfunction

  task automatic idle_ticks(input int t);
    repeat (t * TD) @(negedge clk);
  endtask

  task automatic burst(input int t);
    ir = 1'b0;
    repeat (t * TD) @(negedge clk);
    ir = 1'b1;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] v);
    addr = a;
    we   = 1'b0;
    @(posedge clk);
    #1 v = bus;
    @(negedge clk);
    addr = 8'h00;
    if (a == DADDR) m_valid = 1'b0;
  endtask

  task automatic status_write();
    addr    = BASE;
    we      = 1'b1;
    drv_en  = 1'b1;
    drv_val = 8'($urandom);
    @(negedge clk);
    we     = 1'b0;
    drv_en = 1'b0;
    addr   = 8'h00;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack     = 1'b0;
    m_raise = 1'b0;
  endtask

  task automatic set_frame(input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) begin
      g_gap[i] = gap;
      g_bit[i] = b[7-i] ? ONE_T : ZERO_T;
    end
  endtask

  // mode 0: plain, 1: ACK held across the commit, 2: DATA read on the commit cycle
  task automatic send_frame(input int st, input int mode);
    logic [7:0] sh, oldd, v;
    bit bad, seen;
    bad = 1'b0;
    sh  = 8'h00;
    burst(st);
    if (!in_win(st, START_T)) bad = 1'b1;
    for (int i = 0; i < 8 && !bad; i++) begin
      idle_ticks(g_gap[i]);
      if (g_gap[i] > GAP_MAX) begin
        bad = 1'b1;
        break;
      end
      burst(g_bit[i]);
      if (in_win(g_bit[i], ONE_T))       sh = {sh[6:0], 1'b1};
      else if (in_win(g_bit[i], ZERO_T)) sh = {sh[6:0], 1'b0};
      else                               bad = 1'b1;
    end
    if (bad) begin
      m_ferr = 1'b1;
    end else begin
      oldd = m_data;
      if (mode == 1) begin
        ack = 1'b1;
        repeat (4) @(negedge clk);
        ack = 1'b0;
      end else if (mode == 2) begin
        repeat (3) @(negedge clk);
        addr = DADDR;
        we   = 1'b0;
        @(posedge clk);
        #1 v = bus;
        @(negedge clk);
        addr = 8'h00;
        checks++;
        if (v !== oldd) begin
          errors++;
          $display("FAIL read_commit_collision: got %h expected %h", v, oldd);
        end
      end else begin
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
          @(negedge clk);
          if (raise === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL raise_after_frame: got 0 expected 1 within 8 cycles");
        end
      end
      m_ovr   = m_ovr | m_valid;
      m_valid = 1'b1;
      m_data  = sh;
      m_raise = 1'b1;
    end
    idle_ticks(IDLE_AFTER);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_data = 8'h00; m_valid = 0; m_ovr = 0; m_ferr = 0; m_raise = 0;
    checks++;
    if (raise !== 1'b0) begin errors++; $display("FAIL reset_raise: got %b expected 0", raise); end
    bus_read(BASE, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", v); end
    bus_read(DADDR, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", v); end
    drv_en = 1'b1; drv_val = 8'h5A;
    @(posedge clk);
    #1;
    checks++;
    if (bus !== 8'h5A) begin errors++; $display("FAIL reset_hiz: got %h expected 5a", bus); end
    @(negedge clk);
    drv_en = 1'b0;
  endtask

  task automatic test_valid_frame();
    logic [7:0] v, e;
    set_frame(8'hA5, 12);
    send_frame(96, 0);
    checks++;
    if (raise !== m_raise) begin errors++; $display("FAIL valid_raise: got %b expected %b", raise, m_raise); end
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL valid_status: got %h expected %h", v, e); end
    e = m_data;
    bus_read(DADDR, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL valid_data: got %h expected %h", v, e); end
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL valid_status_after_read: got %h expected %h", v, e); end
    ack_pulse();
    checks++;
    if (raise !== 1'b0) begin errors++; $display("FAIL valid_ack: got %b expected 0", raise); end
  endtask

  task automatic test_tolerance();
    int starts[4];
    int pa[8];
    int pb[8];
    logic [7:0] v, e;
    starts = '{90, 102, 89, 103};
    pa     = '{54, 18, 42, 30, 54, 30, 18, 42};
    pb     = '{42, 30, 54, 18, 18, 54, 30, 42};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        g_gap[i] = 10 + i;
        g_bit[i] = (k % 2 == 0) ? pa[i] : pb[i];
      end
      send_frame(starts[k], 0);
      checks++;
      if (raise !== m_raise) begin errors++; $display("FAIL tol_raise[%0d]: got %b expected %b", k, raise, m_raise); end
      e = m_status();
      bus_read(BASE, v);
      checks++;
      if (v !== e) begin errors++; $display("FAIL tol_status[%0d]: got %h expected %h", k, v, e); end
      e = m_data;
      bus_read(DADDR, v);
      checks++;
      if (v !== e) begin errors++; $display("FAIL tol_data[%0d]: got %h expected %h", k, v, e); end
      if (m_raise) ack_pulse();
      status_write();
    end
  endtask

  task automatic test_gap_timeout();
    logic [7:0] v, e;
    set_frame(8'hC3, 12);
    g_gap[3] = 41;
    send_frame(96, 0);
    checks++;
    if (raise !== 1'b0) begin errors++; $display("FAIL gap_raise: got %b expected 0", raise); end
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL gap_status: got %h expected %h", v, e); end
    set_frame(8'h3C, 12);
    g_gap[7] = 40;
    send_frame(96, 0);
    checks++;
    if (raise !== m_raise) begin errors++; $display("FAIL gap_next_raise: got %b expected %b", raise, m_raise); end
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL gap_next_status: got %h expected %h", v, e); end
    e = m_data;
    bus_read(DADDR, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL gap_next_data: got %h expected %h", v, e); end
    ack_pulse();
    status_write();
  endtask

  task automatic test_overrun();
    logic [7:0] v, e;
    set_frame(8'h11, 10);
    send_frame(96, 0);
    set_frame(8'h22, 14);
    send_frame(96, 0);
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL ovr_status: got %h expected %h", v, e); end
    status_write();
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL ovr_status_cleared: got %h expected %h", v, e); end
    e = m_data;
    bus_read(DADDR, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL ovr_data: got %h expected %h", v, e); end
    ack_pulse();
  endtask

  task automatic test_interrupt();
    logic [7:0] v, e;
    set_frame(8'h5A, 12);
    send_frame(96, 0);
    repeat (20) @(negedge clk);
    checks++;
    if (raise !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", raise); end
    ack_pulse();
    checks++;
    if (raise !== 1'b0) begin errors++; $display("FAIL irq_ack: got %b expected 0", raise); end
    e = m_data;
    bus_read(DADDR, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL irq_data: got %h expected %h", v, e); end
    set_frame(8'hC6, 12);
    send_frame(96, 1);
    checks++;
    if (raise !== m_raise) begin errors++; $display("FAIL irq_commit_ack: got %b expected %b", raise, m_raise); end
    ack_pulse();
    set_frame(8'h69, 12);
    send_frame(96, 2);
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL collision_status: got %h expected %h", v, e); end
    e = m_data;
    bus_read(DADDR, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL collision_data: got %h expected %h", v, e); end
    ack_pulse();
    status_write();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v, e;
    set_frame(8'hB7, 12);
    burst(96);
    for (int i = 0; i < 4; i++) begin
      idle_ticks(g_gap[i]);
      burst(g_bit[i]);
    end
    idle_ticks(g_gap[4]);
    ir = 1'b0;
    repeat (10 * TD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_data = 8'h00; m_valid = 0; m_ovr = 0; m_ferr = 0; m_raise = 0;
    checks++;
    if (raise !== 1'b0) begin errors++; $display("FAIL midrst_raise: got %b expected 0", raise); end
    bus_read(BASE, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL midrst_status: got %h expected 00", v); end
    drv_en = 1'b1; drv_val = 8'hA3;
    @(posedge clk);
    #1;
    checks++;
    if (bus !== 8'hA3) begin errors++; $display("FAIL midrst_hiz: got %h expected a3", bus); end
    @(negedge clk);
    drv_en = 1'b0;
    // the rest of the interrupted burst is far too short to be a START
    repeat (14 * TD) @(negedge clk);
    ir = 1'b1;
    m_ferr = 1'b1;
    idle_ticks(IDLE_AFTER);
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL midrst_residual_status: got %h expected %h", v, e); end
    status_write();
    send_frame(96, 0);
    e = m_status();
    bus_read(BASE, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL midrst_next_status: got %h expected %h", v, e); end
    e = m_data;
    bus_read(DADDR, v);
    checks++;
    if (v !== e) begin errors++; $display("FAIL midrst_next_data: got %h expected %h", v, e); end
    ack_pulse();
  endtask

  task automatic test_random();
    logic [7:0] v, e;
    int st, nom, dev;
    for (int f = 0; f < 10; f++) begin
      st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(84, 108))
                                       : int'($urandom_range(90, 102));
      for (int i = 0; i < 8; i++) begin
        g_gap[i] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(41, 44))
                                                : int'($urandom_range(2, 40));
        nom = ($urandom_range(0, 1) == 1) ? ONE_T : ZERO_T;
        if ($urandom_range(0, 11) == 0) begin
          dev = int'($urandom_range(7, 9));
          g_bit[i] = ($urandom_range(0, 1) == 1) ? nom + dev : nom - dev;
        end else begin
          g_bit[i] = nom + int'($urandom_range(0, 12)) - TOL;
        end
      end
      send_frame(st, 0);
      checks++;
      if (raise !== m_raise) begin errors++; $display("FAIL rnd_raise[%0d]: got %b expected %b", f, raise, m_raise); end
      e = m_status();
      bus_read(BASE, v);
      checks++;
      if (v !== e) begin errors++; $display("FAIL rnd_status[%0d]: got %h expected %h", f, v, e); end
      e = m_data;
      bus_read(DADDR, v);
      checks++;
      if (v !== e) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", f, v, e); end
      if (m_raise) ack_pulse();
      status_write();
    end
  endtask

  initial begin
    rst     = 1'b1;
    ir      = 1'b1;
    we      = 1'b0;
    ack     = 1'b0;
    addr    = 8'h00;
    drv_en  = 1'b0;
    drv_val = 8'h00;
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_tolerance();
    test_gap_timeout();
    test_overrun();
    test_interrupt();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
